// File: rtl/hunch_referee.sv
// hunch_referee: round controller and judge for the 3-player hunch game.
// Collects one binary hunch per player, judges the round, holds the winner.
//
// Ports:
//   CLK, RST (async, active-low)
//   START               open a round (sampled only in IDLE)
//   A/B/C_VALID, _IN    per-player submit strobe and hunch value
//   WINNER_DISP[2:0]    {A,B,C} winner mask; 111=draw, 000=no result
//   A/B/C_DISP          latched hunches of the current/last round
//   SUBMITTED[2:0]      {A,B,C} hunch-latched flags
//   BUSY                high in every state except IDLE
//   ROUND_DONE          one-cycle pulse on the first RESULT cycle
module hunch_referee #(
   parameter int TIMEOUT     = 16,
   parameter int RESULT_HOLD = 1,
   parameter int CNT_W       = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       A_VALID,
   input  logic       A_IN,
   input  logic       B_VALID,
   input  logic       B_IN,
   input  logic       C_VALID,
   input  logic       C_IN,
   output logic [2:0] WINNER_DISP,
   output logic       A_DISP,
   output logic       B_DISP,
   output logic       C_DISP,
   output logic [2:0] SUBMITTED,
   output logic       BUSY,
   output logic       ROUND_DONE
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_JUDGE,
      S_RESULT
   } state_t;

   localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LP_HD_LAST = CNT_W'(RESULT_HOLD - 1);
   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_sub;
   logic [2:0]       r_hunch;
   logic [2:0]       r_win;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_sub_nxt;
   logic [2:0]       w_hunch_nxt;
   logic [2:0]       w_win_nxt;
   logic             w_done_nxt;

   logic [2:0]       w_vld;
   logic [2:0]       w_in;
   logic [2:0]       w_take;
   logic [1:0]       w_nsub;
   logic [2:0]       w_hs;
   logic             w_maj;
   logic [2:0]       w_judge;

   assign w_vld  = {A_VALID, B_VALID, C_VALID};
   assign w_in   = {A_IN, B_IN, C_IN};
   // only players that have not yet submitted may latch (first hunch wins)
   assign w_take = w_vld & ~r_sub;

   assign w_nsub = {1'b0, r_sub[2]} + {1'b0, r_sub[1]} + {1'b0, r_sub[0]};
   assign w_hs   = r_hunch & r_sub;
   assign w_maj  = (r_hunch[2] & r_hunch[1]) |
                   (r_hunch[2] & r_hunch[0]) |
                   (r_hunch[1] & r_hunch[0]);

   always_comb begin
      w_judge = 3'b111;
      case (w_nsub)
         2'd0: w_judge = 3'b111;
         2'd1: w_judge = r_sub;
         // two submitters win together only if they agree
         2'd2: w_judge = ((w_hs == 3'b000) || (w_hs == r_sub)) ?
                         r_sub : 3'b111;
         default: begin
            if ((&r_hunch) || (~|r_hunch))
               w_judge = 3'b111;
            else
               w_judge = ~(r_hunch ^ {3{w_maj}});
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sub_nxt   = r_sub;
      w_hunch_nxt = r_hunch;
      w_win_nxt   = 3'b000;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_nxt = S_COLLECT;
               w_cnt_nxt   = '0;
               w_sub_nxt   = 3'b000;
               w_hunch_nxt = 3'b000;
            end
         end
         S_COLLECT: begin
            w_sub_nxt   = r_sub | w_take;
            w_hunch_nxt = (r_hunch & ~w_take) | (w_in & w_take);
            w_cnt_nxt   = r_cnt + LP_ONE;
            if ((&w_sub_nxt) || (r_cnt == LP_TO_LAST))
               w_state_nxt = S_JUDGE;
         end
         S_JUDGE: begin
            w_state_nxt = S_RESULT;
            w_cnt_nxt   = '0;
            w_win_nxt   = w_judge;
            w_done_nxt  = 1'b1;
         end
         default: begin
            if (r_cnt == LP_HD_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_win_nxt = r_win;
               w_cnt_nxt = r_cnt + LP_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sub   <= 3'b000;
         r_hunch <= 3'b000;
         r_win   <= 3'b000;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sub   <= w_sub_nxt;
         r_hunch <= w_hunch_nxt;
         r_win   <= w_win_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
      end
   end

   assign WINNER_DISP = r_win;
   assign A_DISP      = r_hunch[2];
   assign B_DISP      = r_hunch[1];
   assign C_DISP      = r_hunch[0];
   assign SUBMITTED   = r_sub;
   assign BUSY        = r_busy;
   assign ROUND_DONE  = r_done;

endmodule

// File: tb/tb_hunch_referee.sv
// tb_hunch_referee: directed rounds for hunch_referee with a
// scoreboard queue checked whenever ROUND_DONE is presented.
module tb_hunch_referee;

   localparam int TO = 16;

   typedef struct packed {
      logic [2:0]  win;
      logic [2:0]  disp;
      logic [2:0]  sub;
      logic [31:0] cyc;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       START = 1'b0;
   logic       A_VALID = 1'b0;
   logic       A_IN = 1'b0;
   logic       B_VALID = 1'b0;
   logic       B_IN = 1'b0;
   logic       C_VALID = 1'b0;
   logic       C_IN = 1'b0;
   logic [2:0] WINNER_DISP;
   logic       A_DISP;
   logic       B_DISP;
   logic       C_DISP;
   logic [2:0] SUBMITTED;
   logic       BUSY;
   logic       ROUND_DONE;

   logic [31:0] cyc = 0;
   int          n_run = 0;
   int          n_fail = 0;
   exp_t        q[$];

   hunch_referee #(
      .TIMEOUT(TO),
      .RESULT_HOLD(1),
      .CNT_W(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .START(START),
      .A_VALID(A_VALID),
      .A_IN(A_IN),
      .B_VALID(B_VALID),
      .B_IN(B_IN),
      .C_VALID(C_VALID),
      .C_IN(C_IN),
      .WINNER_DISP(WINNER_DISP),
      .A_DISP(A_DISP),
      .B_DISP(B_DISP),
      .C_DISP(C_DISP),
      .SUBMITTED(SUBMITTED),
      .BUSY(BUSY),
      .ROUND_DONE(ROUND_DONE)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] w, input logic [2:0] d,
                       input logic [2:0] s, input logic [31:0] c);
      exp_t e;
      e.win  = w;
      e.disp = d;
      e.sub  = s;
      e.cyc  = c;
      q.push_back(e);
   endtask

   task automatic start_round(output logic [31:0] s);
      @(negedge CLK);
      START = 1'b1;
      s = cyc;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic submit(input logic [2:0] v, input logic [2:0] h,
                         output logic [31:0] l);
      {A_VALID, B_VALID, C_VALID} = v;
      {A_IN, B_IN, C_IN} = h;
      l = cyc;
      @(negedge CLK);
      {A_VALID, B_VALID, C_VALID} = 3'b000;
      {A_IN, B_IN, C_IN} = 3'b000;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (BUSY && k < 200) begin
         @(negedge CLK);
         k++;
      end
      chk({nm, "_idle"}, {31'd0, BUSY}, 0);
      @(negedge CLK);
   endtask

   task automatic to_round(input string nm, input logic [2:0] v,
                           input logic [2:0] h, input logic [2:0] w);
      logic [31:0] s;
      logic [31:0] l;
      start_round(s);
      push(w, h & v, v, s + TO + 2);
      submit(v, h, l);
      wait_idle(nm);
   endtask

   task automatic fast_round(input string nm, input logic [2:0] h,
                             input logic [2:0] w);
      logic [31:0] s;
      logic [31:0] l;
      start_round(s);
      submit(3'b111, h, l);
      push(w, h, 3'b111, l + 2);
      wait_idle(nm);
   endtask

   // monitor: pops an expectation on every ROUND_DONE
   initial begin
      exp_t e;
      logic after;
      after = 1'b0;
      forever begin
         @(negedge CLK);
         if (after) begin
            chk("win_clear", {29'd0, WINNER_DISP}, 0);
            chk("done_width", {31'd0, ROUND_DONE}, 0);
            after = 1'b0;
         end
         if (ROUND_DONE) begin
            if (q.size() == 0) begin
               n_run++;
               n_fail++;
               $display("FAIL unexpected_done: got done at %0d, want none",
                        cyc);
            end else begin
               e = q.pop_front();
               chk("winner", {29'd0, WINNER_DISP}, {29'd0, e.win});
               chk("disp", {29'd0, A_DISP, B_DISP, C_DISP},
                   {29'd0, e.disp});
               chk("submitted", {29'd0, SUBMITTED}, {29'd0, e.sub});
               chk("latency", cyc, e.cyc);
            end
            after = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] s;
      logic [31:0] l;
      int k;

      repeat (3) @(negedge CLK);
      chk("rst_win", {29'd0, WINNER_DISP}, 0);
      chk("rst_disp", {29'd0, A_DISP, B_DISP, C_DISP}, 0);
      chk("rst_sub", {29'd0, SUBMITTED}, 0);
      chk("rst_busy", {30'd0, BUSY, ROUND_DONE}, 0);
      RST = 1'b1;
      @(negedge CLK);

      // T1: all three in one cycle, majority 1 -> A,B
      fast_round("t1", 3'b110, 3'b110);

      // T2: all zero over three cycles -> draw
      start_round(s);
      chk("t2_entry", {30'd0, BUSY, SUBMITTED[2]}, 32'd2);
      submit(3'b100, 3'b000, l);
      submit(3'b010, 3'b000, l);
      submit(3'b001, 3'b000, l);
      push(3'b111, 3'b000, 3'b111, l + 2);
      wait_idle("t2");

      // T3: only B -> 010 after timeout
      to_round("t3", 3'b010, 3'b010, 3'b010);

      // T4: A twice (1 then 0), C=0 -> A keeps 1, differ -> draw
      start_round(s);
      push(3'b111, 3'b100, 3'b101, s + TO + 2);
      submit(3'b100, 3'b100, l);
      submit(3'b100, 3'b000, l);
      submit(3'b001, 3'b000, l);
      wait_idle("t4");

      // nobody submits -> draw
      to_round("none", 3'b000, 3'b000, 3'b111);
      // two agreeing players
      to_round("ac_eq", 3'b101, 3'b101, 3'b101);
      to_round("bc_eq", 3'b011, 3'b000, 3'b011);
      // three players, various majorities
      fast_round("maj_ac", 3'b010, 3'b101);
      fast_round("maj_bc", 3'b100, 3'b011);
      fast_round("all_one", 3'b111, 3'b111);

      // T5: START ignored in COLLECT and RESULT
      start_round(s);
      push(3'b100, 3'b100, 3'b100, s + TO + 2);
      submit(3'b100, 3'b100, l);
      START = 1'b1;
      repeat (3) @(negedge CLK);
      chk("t5_busy", {31'd0, BUSY}, 1);
      chk("t5_sub", {29'd0, SUBMITTED}, {29'd0, 3'b100});
      START = 1'b0;
      k = 0;
      while (!ROUND_DONE && k < 100) begin
         @(negedge CLK);
         k++;
      end
      chk("t5_done_seen", {31'd0, ROUND_DONE}, 1);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("t5_result_start", {31'd0, BUSY}, 0);
      @(negedge CLK);
      chk("t5_still_idle", {31'd0, BUSY}, 0);

      // START in the IDLE cycle right after RESULT
      fast_round("back2back", 3'b000, 3'b111);

      // T6: reset mid-COLLECT aborts, then a clean round
      start_round(s);
      submit(3'b110, 3'b100, l);
      chk("t6_pre_sub", {29'd0, SUBMITTED}, {29'd0, 3'b110});
      #1;
      RST = 1'b0;
      #1;
      chk("t6_rst_outs", {22'd0, WINNER_DISP, A_DISP, B_DISP, C_DISP,
                          SUBMITTED, BUSY, ROUND_DONE}, 0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      start_round(s);
      chk("t6_clean", {26'd0, SUBMITTED, A_DISP, B_DISP, C_DISP}, 0);
      submit(3'b111, 3'b001, l);
      push(3'b110, 3'b001, 3'b111, l + 2);
      wait_idle("t6");

      repeat (2) @(negedge CLK);
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
